// File: rtl/ahb_write_buffer_pkg.sv
// Shared AHB-Lite encodings and the downstream FSM state type for the posted-write buffer.
package ahb_write_buffer_pkg;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_NSEQ   = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;
  localparam logic [2:0] HBURST_SINGLE = 3'b000;
  localparam logic [3:0] HPROT_DEFAULT = 4'b0011;

  typedef enum logic [1:0] {
    D_IDLE    = 2'd0,
    D_WR_DATA = 2'd1,
    D_RD_DATA = 2'd2
  } dst_state_t;

endpackage

// File: rtl/ahb_write_buffer_fifo.sv
// Register-based synchronous FIFO; head is the oldest entry, valid whenever empty is low.
module sync_fifo_reg #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         head,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_LEVEL = (AW + 1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic             do_push;
  logic             do_pop;

  // Requests against a full or empty FIFO are dropped rather than corrupting state.
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign full    = (count == FULL_LEVEL);
  assign empty   = (count == '0);
  assign level   = count;
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= push_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/ahb_write_buffer.sv
// Posted-write buffer between an AHB-Lite master and slave: writes complete upstream with
// zero wait states while space exists; reads wait for the buffer to drain, then pass through.
module ahb_write_buffer
  import ahb_write_buffer_pkg::*;
#(
  parameter int W_ADDR = 32,
  parameter int W_DATA = 32,
  parameter int DEPTH  = 4
) (
  input  logic              clk,
  input  logic              rst,
  output logic              src_hready_resp,
  input  logic              src_hready,
  output logic              src_hresp,
  input  logic [W_ADDR-1:0] src_haddr,
  input  logic              src_hwrite,
  input  logic [1:0]        src_htrans,
  input  logic [2:0]        src_hsize,
  input  logic [W_DATA-1:0] src_hwdata,
  output logic [W_DATA-1:0] src_hrdata,
  input  logic              dst_hready_resp,
  output logic              dst_hready,
  input  logic              dst_hresp,
  output logic [W_ADDR-1:0] dst_haddr,
  output logic              dst_hwrite,
  output logic [1:0]        dst_htrans,
  output logic [2:0]        dst_hsize,
  output logic [2:0]        dst_hburst,
  output logic [3:0]        dst_hprot,
  output logic              dst_hmastlock,
  output logic [W_DATA-1:0] dst_hwdata,
  input  logic [W_DATA-1:0] dst_hrdata,
  output logic              wr_err,
  input  logic              wr_err_clr,
  output logic              empty
);

  localparam int ENTRY_W = W_ADDR + 3 + W_DATA;
  localparam int LVL_W   = $clog2(DEPTH) + 1;

  logic              dph_valid;
  logic              dph_write;
  logic [W_ADDR-1:0] dph_addr;
  logic [2:0]        dph_size;
  dst_state_t        d_state;

  logic               fifo_push;
  logic               fifo_pop;
  logic               fifo_full;
  logic               fifo_empty;
  logic [LVL_W-1:0]   fifo_level;
  logic [ENTRY_W-1:0] push_entry;
  logic [ENTRY_W-1:0] head_entry;
  logic [W_ADDR-1:0]  head_addr;
  logic [2:0]         head_size;
  logic [W_DATA-1:0]  head_data;

  logic addr_phase;
  logic rd_pending;
  logic issue_wr;
  logic issue_rd;

  assign addr_phase = src_hready && ((src_htrans == HTRANS_NSEQ) || (src_htrans == HTRANS_SEQ));
  assign rd_pending = dph_valid && !dph_write;
  assign push_entry = {dph_addr, dph_size, src_hwdata};
  assign {head_addr, head_size, head_data} = head_entry;

  // A write data phase completes exactly when it is pushed; a pop in the same cycle does not help.
  assign fifo_push = dph_valid && dph_write && !fifo_full;
  assign fifo_pop  = (d_state == D_WR_DATA) && dst_hready_resp;

  // Buffered writes always go first so a pending read observes every earlier write.
  assign issue_wr = (d_state == D_IDLE) && !fifo_empty;
  assign issue_rd = (d_state == D_IDLE) && fifo_empty && rd_pending;

  sync_fifo_reg #(
    .WIDTH (ENTRY_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (fifo_push),
    .push_data (push_entry),
    .pop       (fifo_pop),
    .head      (head_entry),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .level     (fifo_level)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      dph_valid <= 1'b0;
      dph_write <= 1'b0;
      dph_addr  <= '0;
      dph_size  <= '0;
    end else if (src_hready) begin
      dph_valid <= addr_phase;
      if (addr_phase) begin
        dph_write <= src_hwrite;
        dph_addr  <= src_haddr;
        dph_size  <= src_hsize;
      end
    end
  end

  always_comb begin
    src_hready_resp = 1'b1;
    src_hresp       = 1'b0;
    src_hrdata      = '0;
    if (d_state == D_RD_DATA) begin
      src_hrdata = dst_hrdata;
    end
    if (dph_valid) begin
      if (dph_write) begin
        src_hready_resp = !fifo_full;
      end else if (d_state == D_RD_DATA) begin
        src_hready_resp = dst_hready_resp;
        src_hresp       = dst_hresp;
      end else begin
        src_hready_resp = 1'b0;
      end
    end
  end

  always_comb begin
    dst_htrans = HTRANS_IDLE;
    dst_haddr  = '0;
    dst_hwrite = 1'b0;
    dst_hsize  = 3'b000;
    dst_hwdata = '0;
    if (issue_wr) begin
      dst_htrans = HTRANS_NSEQ;
      dst_haddr  = head_addr;
      dst_hwrite = 1'b1;
      dst_hsize  = head_size;
    end else if (issue_rd) begin
      dst_htrans = HTRANS_NSEQ;
      dst_haddr  = dph_addr;
      dst_hsize  = dph_size;
    end
    if (d_state == D_WR_DATA) begin
      dst_hwdata = head_data;
    end
  end

  // Every transfer returns through D_IDLE, which guarantees an IDLE cycle between transfers.
  always_ff @(posedge clk) begin
    if (rst) begin
      d_state <= D_IDLE;
      wr_err  <= 1'b0;
    end else begin
      case (d_state)
        D_IDLE: begin
          if (dst_hready_resp) begin
            if (issue_wr)      d_state <= D_WR_DATA;
            else if (issue_rd) d_state <= D_RD_DATA;
          end
        end
        D_WR_DATA: if (dst_hready_resp) d_state <= D_IDLE;
        D_RD_DATA: if (dst_hready_resp) d_state <= D_IDLE;
        default:   d_state <= D_IDLE;
      endcase
      if (fifo_pop && dst_hresp) wr_err <= 1'b1;
      else if (wr_err_clr)       wr_err <= 1'b0;
    end
  end

  assign empty         = (fifo_level == '0) && (d_state == D_IDLE);
  assign dst_hready    = dst_hready_resp;
  assign dst_hburst    = HBURST_SINGLE;
  assign dst_hprot     = HPROT_DEFAULT;
  assign dst_hmastlock = 1'b0;

endmodule

// File: tb/tb_ahb_write_buffer.sv
// Directed bench for ahb_write_buffer: one task per scenario, hand-computed expectations.
module tb_ahb_write_buffer;

  logic        clk = 1'b0;
  logic        rst;
  logic        src_hready_resp;
  logic        src_hready;
  logic        src_hresp;
  logic [31:0] src_haddr;
  logic        src_hwrite;
  logic [1:0]  src_htrans;
  logic [2:0]  src_hsize;
  logic [31:0] src_hwdata;
  logic [31:0] src_hrdata;
  logic        dst_hready_resp;
  logic        dst_hready;
  logic        dst_hresp;
  logic [31:0] dst_haddr;
  logic        dst_hwrite;
  logic [1:0]  dst_htrans;
  logic [2:0]  dst_hsize;
  logic [2:0]  dst_hburst;
  logic [3:0]  dst_hprot;
  logic        dst_hmastlock;
  logic [31:0] dst_hwdata;
  logic [31:0] dst_hrdata;
  logic        wr_err;
  logic        wr_err_clr;
  logic        empty;

  int checks = 0;
  int passed = 0;

  // Single upstream slave: the bus HREADY is this block's own HREADYOUT.
  assign src_hready = src_hready_resp;

  always #5 clk = ~clk;

  ahb_write_buffer #(.W_ADDR(32), .W_DATA(32), .DEPTH(4)) dut (
    .clk             (clk),
    .rst             (rst),
    .src_hready_resp (src_hready_resp),
    .src_hready      (src_hready),
    .src_hresp       (src_hresp),
    .src_haddr       (src_haddr),
    .src_hwrite      (src_hwrite),
    .src_htrans      (src_htrans),
    .src_hsize       (src_hsize),
    .src_hwdata      (src_hwdata),
    .src_hrdata      (src_hrdata),
    .dst_hready_resp (dst_hready_resp),
    .dst_hready      (dst_hready),
    .dst_hresp       (dst_hresp),
    .dst_haddr       (dst_haddr),
    .dst_hwrite      (dst_hwrite),
    .dst_htrans      (dst_htrans),
    .dst_hsize       (dst_hsize),
    .dst_hburst      (dst_hburst),
    .dst_hprot       (dst_hprot),
    .dst_hmastlock   (dst_hmastlock),
    .dst_hwdata      (dst_hwdata),
    .dst_hrdata      (dst_hrdata),
    .wr_err          (wr_err),
    .wr_err_clr      (wr_err_clr),
    .empty           (empty)
  );

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic addr_phase(input logic [31:0] a, input logic wr);
    src_htrans = 2'b10;
    src_haddr  = a;
    src_hwrite = wr;
    src_hsize  = 3'd2;
  endtask

  task automatic idle_phase();
    src_htrans = 2'b00;
    src_haddr  = 32'h0;
    src_hwrite = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    dst_hrdata = 32'hFFFF_FFFF;
    cyc(); cyc(); #1;
    checks++; if (src_hready_resp !== 1'b1) $display("FAIL reset_src_hready_resp: got %b expected 1", src_hready_resp); else passed++;
    checks++; if (src_hresp !== 1'b0) $display("FAIL reset_src_hresp: got %b expected 0", src_hresp); else passed++;
    checks++; if (dst_htrans !== 2'b00) $display("FAIL reset_dst_htrans: got %b expected 00", dst_htrans); else passed++;
    checks++; if (wr_err !== 1'b0) $display("FAIL reset_wr_err: got %b expected 0", wr_err); else passed++;
    checks++; if (empty !== 1'b1) $display("FAIL reset_empty: got %b expected 1", empty); else passed++;
    checks++; if (src_hrdata !== 32'h0) $display("FAIL reset_src_hrdata: got %h expected 0", src_hrdata); else passed++;
    checks++; if (dst_hburst !== 3'b000) $display("FAIL tie_hburst: got %b expected 000", dst_hburst); else passed++;
    checks++; if (dst_hprot !== 4'b0011) $display("FAIL tie_hprot: got %b expected 0011", dst_hprot); else passed++;
    checks++; if (dst_hmastlock !== 1'b0) $display("FAIL tie_hmastlock: got %b expected 0", dst_hmastlock); else passed++;
    cyc(); rst = 1'b0; #1;
  endtask

  task automatic test_single_write();
    dst_hready_resp = 1'b1;
    cyc(); addr_phase(32'h1000, 1'b1); #1;
    cyc(); idle_phase(); src_hwdata = 32'hDEAD_BEEF; #1;
    checks++; if (src_hready_resp !== 1'b1) $display("FAIL single_data_phase_ready: got %b expected 1", src_hready_resp); else passed++;
    checks++; if (dst_htrans !== 2'b00) $display("FAIL single_no_early_nseq: got %b expected 00", dst_htrans); else passed++;
    cyc(); #1;
    checks++; if (dst_htrans !== 2'b10) $display("FAIL single_nseq: got %b expected 10", dst_htrans); else passed++;
    checks++; if (dst_haddr !== 32'h1000) $display("FAIL single_haddr: got %h expected 00001000", dst_haddr); else passed++;
    checks++; if (dst_hsize !== 3'd2) $display("FAIL single_hsize: got %0d expected 2", dst_hsize); else passed++;
    checks++; if (dst_hwrite !== 1'b1) $display("FAIL single_hwrite: got %b expected 1", dst_hwrite); else passed++;
    checks++; if (empty !== 1'b0) $display("FAIL single_not_empty: got %b expected 0", empty); else passed++;
    cyc(); #1;
    checks++; if (dst_hwdata !== 32'hDEAD_BEEF) $display("FAIL single_hwdata: got %h expected deadbeef", dst_hwdata); else passed++;
    checks++; if (dst_htrans !== 2'b00) $display("FAIL single_gap_idle: got %b expected 00", dst_htrans); else passed++;
    cyc(); #1;
    checks++; if (empty !== 1'b1) $display("FAIL single_empty_after: got %b expected 1", empty); else passed++;
  endtask

  task automatic test_fill_stall();
    logic [31:0] exp_addr [5];
    logic [31:0] exp_data [5];
    int seen;
    logic nseq_prev;
    for (int i = 0; i < 5; i++) begin
      exp_addr[i] = 32'h4000 + 32'(i * 4);
      exp_data[i] = 32'hA000_0000 + 32'(i);
    end
    dst_hready_resp = 1'b0;
    cyc(); addr_phase(exp_addr[0], 1'b1); #1;
    for (int i = 1; i < 5; i++) begin
      cyc(); src_hwdata = exp_data[i-1]; addr_phase(exp_addr[i], 1'b1); #1;
      checks++; if (src_hready_resp !== 1'b1) $display("FAIL fill_zero_wait_%0d: got %b expected 1", i - 1, src_hready_resp); else passed++;
    end
    cyc(); src_hwdata = exp_data[4]; idle_phase(); #1;
    checks++; if (src_hready_resp !== 1'b0) $display("FAIL fill_fifth_stalls: got %b expected 0", src_hready_resp); else passed++;
    cyc(); #1;
    checks++; if (src_hready_resp !== 1'b0) $display("FAIL fill_still_stalled: got %b expected 0", src_hready_resp); else passed++;
    checks++; if (dst_haddr !== exp_addr[0]) $display("FAIL fill_head_addr_held: got %h expected %h", dst_haddr, exp_addr[0]); else passed++;
    cyc(); dst_hready_resp = 1'b1; #1;
    seen = 0;
    nseq_prev = 1'b0;
    for (int c = 0; c < 30 && seen < 5; c++) begin
      if (c < 3) begin
        checks++; if (src_hready_resp !== ((c == 2) ? 1'b1 : 1'b0)) $display("FAIL fill_release_ready_c%0d: got %b expected %b", c, src_hready_resp, (c == 2) ? 1'b1 : 1'b0); else passed++;
      end
      if (nseq_prev) begin
        checks++; if (dst_hwdata !== exp_data[seen]) $display("FAIL fill_drain_data_%0d: got %h expected %h", seen, dst_hwdata, exp_data[seen]); else passed++;
        seen++;
      end
      if (dst_htrans == 2'b10 && seen < 5) begin
        checks++; if (dst_haddr !== exp_addr[seen]) $display("FAIL fill_drain_addr_%0d: got %h expected %h", seen, dst_haddr, exp_addr[seen]); else passed++;
      end
      nseq_prev = (dst_htrans == 2'b10) && dst_hready_resp;
      cyc(); #1;
    end
    checks++; if (seen !== 5) $display("FAIL fill_drain_count: got %0d expected 5", seen); else passed++;
    checks++; if (empty !== 1'b1) $display("FAIL fill_empty_after: got %b expected 1", empty); else passed++;
  endtask

  task automatic test_ordering();
    int writes_done;
    logic read_seen;
    logic nseq_prev_w;
    dst_hready_resp = 1'b1;
    cyc(); addr_phase(32'h1000, 1'b1); #1;
    cyc(); src_hwdata = 32'h11; addr_phase(32'h1004, 1'b1); #1;
    cyc(); src_hwdata = 32'h22; addr_phase(32'h1000, 1'b0); #1;
    nseq_prev_w = (dst_htrans == 2'b10) && dst_hwrite;
    cyc(); idle_phase(); dst_hrdata = 32'h1234_5678; #1;
    writes_done = 0;
    read_seen = 1'b0;
    for (int c = 0; c < 20 && !read_seen; c++) begin
      if (nseq_prev_w) writes_done++;
      if (dst_htrans == 2'b10 && !dst_hwrite) begin
        read_seen = 1'b1;
        checks++; if (writes_done !== 2) $display("FAIL order_writes_before_read: got %0d expected 2", writes_done); else passed++;
        checks++; if (dst_haddr !== 32'h1000) $display("FAIL order_read_addr: got %h expected 00001000", dst_haddr); else passed++;
      end
      checks++; if (src_hready_resp !== 1'b0) $display("FAIL order_read_waits_c%0d: got %b expected 0", c, src_hready_resp); else passed++;
      nseq_prev_w = (dst_htrans == 2'b10) && dst_hwrite && dst_hready_resp;
      cyc(); #1;
    end
    checks++; if (read_seen !== 1'b1) $display("FAIL order_read_issued: got %b expected 1", read_seen); else passed++;
    checks++; if (src_hready_resp !== 1'b1) $display("FAIL order_read_complete: got %b expected 1", src_hready_resp); else passed++;
    checks++; if (src_hrdata !== 32'h1234_5678) $display("FAIL order_hrdata: got %h expected 12345678", src_hrdata); else passed++;
    checks++; if (src_hresp !== 1'b0) $display("FAIL order_hresp: got %b expected 0", src_hresp); else passed++;
    cyc(); #1;
    checks++; if (src_hrdata !== 32'h0) $display("FAIL order_hrdata_zero_after: got %h expected 0", src_hrdata); else passed++;
    checks++; if (empty !== 1'b1) $display("FAIL order_empty_after: got %b expected 1", empty); else passed++;
  endtask

  task automatic test_write_error();
    dst_hready_resp = 1'b1;
    dst_hresp = 1'b0;
    cyc(); addr_phase(32'h2000, 1'b1); #1;
    cyc(); idle_phase(); src_hwdata = 32'hCAFE_0001; #1;
    checks++; if (src_hresp !== 1'b0) $display("FAIL werr_upstream_okay: got %b expected 0", src_hresp); else passed++;
    cyc(); #1;
    checks++; if (dst_htrans !== 2'b10) $display("FAIL werr_nseq: got %b expected 10", dst_htrans); else passed++;
    cyc(); dst_hready_resp = 1'b0; dst_hresp = 1'b1; #1;
    checks++; if (dst_hwdata !== 32'hCAFE_0001) $display("FAIL werr_hwdata: got %h expected cafe0001", dst_hwdata); else passed++;
    checks++; if (wr_err !== 1'b0) $display("FAIL werr_not_yet: got %b expected 0", wr_err); else passed++;
    cyc(); dst_hready_resp = 1'b1; #1;
    cyc(); dst_hresp = 1'b0; wr_err_clr = 1'b1; #1;
    checks++; if (wr_err !== 1'b1) $display("FAIL werr_set: got %b expected 1", wr_err); else passed++;
    checks++; if (empty !== 1'b1) $display("FAIL werr_empty: got %b expected 1", empty); else passed++;
    cyc(); wr_err_clr = 1'b0; #1;
    checks++; if (wr_err !== 1'b0) $display("FAIL werr_cleared: got %b expected 0", wr_err); else passed++;
    // Second error completes while clear is held: the set must win.
    cyc(); addr_phase(32'h2004, 1'b1); #1;
    cyc(); idle_phase(); src_hwdata = 32'hCAFE_0002; #1;
    cyc(); #1;
    cyc(); dst_hready_resp = 1'b0; dst_hresp = 1'b1; wr_err_clr = 1'b1; #1;
    cyc(); dst_hready_resp = 1'b1; #1;
    cyc(); dst_hresp = 1'b0; wr_err_clr = 1'b0; #1;
    checks++; if (wr_err !== 1'b1) $display("FAIL werr_set_beats_clr: got %b expected 1", wr_err); else passed++;
    cyc(); wr_err_clr = 1'b1; #1;
    cyc(); wr_err_clr = 1'b0; #1;
  endtask

  task automatic test_read_error();
    dst_hready_resp = 1'b1;
    dst_hresp = 1'b0;
    cyc(); addr_phase(32'h3000, 1'b0); #1;
    cyc(); idle_phase(); #1;
    checks++; if (dst_htrans !== 2'b10 || dst_hwrite !== 1'b0) $display("FAIL rerr_nseq_read: got %b/%b expected 10/0", dst_htrans, dst_hwrite); else passed++;
    checks++; if (dst_haddr !== 32'h3000) $display("FAIL rerr_addr: got %h expected 00003000", dst_haddr); else passed++;
    checks++; if (src_hready_resp !== 1'b0) $display("FAIL rerr_wait: got %b expected 0", src_hready_resp); else passed++;
    cyc(); dst_hready_resp = 1'b0; dst_hresp = 1'b1; #1;
    checks++; if (src_hresp !== 1'b1 || src_hready_resp !== 1'b0) $display("FAIL rerr_first_cycle: got %b/%b expected 1/0", src_hresp, src_hready_resp); else passed++;
    cyc(); dst_hready_resp = 1'b1; #1;
    checks++; if (src_hresp !== 1'b1 || src_hready_resp !== 1'b1) $display("FAIL rerr_second_cycle: got %b/%b expected 1/1", src_hresp, src_hready_resp); else passed++;
    cyc(); dst_hresp = 1'b0; #1;
    checks++; if (src_hresp !== 1'b0) $display("FAIL rerr_hresp_after: got %b expected 0", src_hresp); else passed++;
    checks++; if (empty !== 1'b1) $display("FAIL rerr_empty_after: got %b expected 1", empty); else passed++;
  endtask

  task automatic test_reset_mid_drain();
    int nseq_count;
    dst_hready_resp = 1'b0;
    cyc(); addr_phase(32'h5000, 1'b1); #1;
    cyc(); src_hwdata = 32'hA1; addr_phase(32'h5004, 1'b1); #1;
    cyc(); src_hwdata = 32'hA2; addr_phase(32'h5008, 1'b1); #1;
    cyc(); src_hwdata = 32'hA3; idle_phase(); #1;
    cyc(); rst = 1'b1; #1;
    checks++; if (empty !== 1'b0 || dst_htrans !== 2'b10) $display("FAIL rst_mid_buffered: got %b/%b expected 0/10", empty, dst_htrans); else passed++;
    cyc(); rst = 1'b0; dst_hready_resp = 1'b1; #1;
    checks++; if (empty !== 1'b1) $display("FAIL rst_mid_empty: got %b expected 1", empty); else passed++;
    checks++; if (dst_htrans !== 2'b00) $display("FAIL rst_mid_htrans: got %b expected 00", dst_htrans); else passed++;
    nseq_count = 0;
    for (int c = 0; c < 6; c++) begin
      if (dst_htrans == 2'b10) nseq_count++;
      cyc(); #1;
    end
    checks++; if (nseq_count !== 0) $display("FAIL rst_mid_no_writes: got %0d expected 0", nseq_count); else passed++;
  endtask

  initial begin
    rst = 1'b1;
    src_haddr = 32'h0;
    src_hwrite = 1'b0;
    src_htrans = 2'b00;
    src_hsize = 3'd2;
    src_hwdata = 32'h0;
    dst_hready_resp = 1'b1;
    dst_hresp = 1'b0;
    dst_hrdata = 32'h0;
    wr_err_clr = 1'b0;
    test_reset();
    test_single_write();
    test_fill_stall();
    test_ordering();
    test_write_error();
    test_read_error();
    test_reset_mid_drain();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/ahb_write_buffer.md
Name: ahb_write_buffer

Overview:
Posted-write buffer between an upstream AHB-Lite master and a downstream AHB-Lite slave. It is the write-side companion to the read-only cache.
- Upstream writes complete with zero wait states while buffer space exists.
- Buffered writes drain downstream as single transfers.
- Reads wait until all buffered writes have drained, which keeps read-after-write ordering, then pass straight through.

Parameters:
W_ADDR, 32, address width
W_DATA, 32, data bus width (power of two, >=8)
DEPTH, 4, buffer entries (power of two, >=2)

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
src_hready_resp  out  1  upstream HREADYOUT
src_hready  in  1  upstream HREADY
src_hresp  out  1  upstream HRESP
src_haddr  in  W_ADDR  upstream HADDR
src_hwrite  in  1  upstream HWRITE
src_htrans  in  2  upstream HTRANS
src_hsize  in  3  upstream HSIZE
src_hwdata  in  W_DATA  upstream HWDATA
src_hrdata  out  W_DATA  upstream HRDATA
dst_hready_resp  in  1  downstream HREADYOUT
dst_hready  out  1  downstream HREADY (= dst_hready_resp)
dst_hresp  in  1  downstream HRESP
dst_haddr  out  W_ADDR  downstream HADDR
dst_hwrite  out  1  downstream HWRITE
dst_htrans  out  2  downstream HTRANS (IDLE or NSEQ only)
dst_hsize  out  3  downstream HSIZE
dst_hburst  out  3  tied 3'b000 (SINGLE)
dst_hprot  out  4  tied 4'b0011
dst_hmastlock  out  1  tied 0
dst_hwdata  out  W_DATA  downstream HWDATA
dst_hrdata  in  W_DATA  downstream HRDATA
wr_err  out  1  sticky flag: a posted write received an ERROR response
wr_err_clr  in  1  clears wr_err
empty  out  1  buffer empty and downstream FSM in D_IDLE

Behaviour:
- Single clock; reset synchronous active-high.
- Reset values:
  - FIFO empty; no upstream data phase pending; D_IDLE.
  - src_hready_resp=1, src_hresp=0, dst_htrans=IDLE, wr_err=0, empty=1.
  - Reset mid-drain discards all buffered entries and any in-flight transfer state.
- Upstream address phase (src_hready && src_htrans[1]) registers dph_valid, dph_write, addr and size for the following data phase.
- Upstream write data phase:
  - src_hready_resp = !full, using the registered count.
  - When completing, push {addr, size, src_hwdata}.
  - Pop and push in the same cycle while full still stalls one cycle; the stall is decided, not an error.
- Upstream read data phase: src_hready_resp=0 until the forwarded downstream read completes.
- No pending data phase: src_hready_resp=1, src_hresp=0 (IDLE-to-OKAY).
- Downstream FSM states: D_IDLE, D_WR_DATA, D_RD_DATA.
  - D_IDLE, FIFO non-empty: drive NSEQ write with head addr and size. If dst_hready, go to D_WR_DATA. Writes take priority over a pending read.
  - D_IDLE, FIFO empty and upstream read data phase pending: drive NSEQ read with the captured addr and size. If dst_hready, go to D_RD_DATA.
  - D_WR_DATA: htrans=IDLE, dst_hwdata = head data. On dst_hready_resp: pop; if dst_hresp, set wr_err; go to D_IDLE.
  - D_RD_DATA: htrans=IDLE. src_hrdata = dst_hrdata, src_hready_resp = dst_hready_resp, src_hresp = dst_hresp (two-cycle error passes through combinationally). Go to D_IDLE on dst_hready_resp.
- Downstream transfers are never pipelined: there is at least one IDLE cycle between them. Write throughput is one per two cycles with zero-wait downstream.
- wr_err: set has priority over wr_err_clr in the same cycle.
- src_hrdata outside D_RD_DATA is 0.
- FIFO pointers are log2(DEPTH) bits and wrap naturally. The count is log2(DEPTH)+1 bits.

Decomposition:
- Shared package holds HTRANS_IDLE/NSEQ/SEQ, HBURST_SINGLE and the HPROT default constants.
- One natural sub-module: sync_fifo_reg, a register-based FIFO with parameters WIDTH and DEPTH, ports push/pop/full/empty/level, and synchronous active-high reset.
- Entry width is W_ADDR+3+W_DATA.

Test Plan:
- Single write: write 0x1000 / 0xDEADBEEF with zero-wait downstream -> src_hready_resp=1 in the data phase. Next cycle dst NSEQ haddr=0x1000, hsize=2, hwrite=1; following cycle dst_hwdata=0xDEADBEEF; then empty=1.
- Fill and stall: dst_hready_resp held 0, five back-to-back writes -> four complete with zero wait; the fifth data phase stalls. After dst_hready_resp=1, it completes after the first pop (+1 cycle).
- Ordering: writes 0x1000 and 0x1004, then read 0x1000 -> read NSEQ appears on dst only after both write data phases complete; src_hrdata = dst_hrdata (0x12345678) in the completing cycle.
- Posted write error: downstream ERROR on a write -> wr_err=1, upstream sees OKAY. Pulse wr_err_clr -> wr_err=0.
- Read error: downstream two-cycle ERROR -> upstream sees hresp=1/hready=0, then hresp=1/hready=1, on the same cycles.
- Reset mid-drain: rst asserted with 3 entries buffered -> next cycle empty=1, dst_htrans=IDLE, no further downstream writes.
